// File: rtl/fb_double_buffer_pkg.sv
// rtl/fb_double_buffer_pkg.sv - shared geometry, widths and FSM encoding for the framebuffer
package fb_double_buffer_pkg;
  localparam int FB_W    = 58;
  localparam int FB_H    = 60;
  localparam int COORD_W = 6;
  localparam int ADDR_W  = 12;
  localparam int PIX_W   = 8;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int PROD_W  = 2 * COORD_W + 1;
  localparam logic VS_ACT = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Full-width linear address so out-of-range coordinates can never alias a valid pixel.
  function automatic logic [PROD_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    logic [PROD_W-1:0] p;
    p = PROD_W'(y) * PROD_W'(FB_W) + PROD_W'(x);
    return p;
  endfunction
endpackage

// File: rtl/fb_double_buffer_ram_2p.sv
// rtl/fb_double_buffer_ram_2p.sv - simple dual-port synchronous RAM, one write port, registered read
module fb_ram_2p
  import fb_double_buffer_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);
  logic [PIX_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fb_double_buffer.sv
// rtl/fb_double_buffer.sv - double-buffered greyscale framebuffer with vsync-aligned swap
module fb_double_buffer
  import fb_double_buffer_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [PIX_W-1:0]   wr_color,
  input  logic               clr_valid,
  output logic               clr_ready,
  input  logic [PIX_W-1:0]   clr_color,
  input  logic               swap_req,
  output logic               swap_pending,
  output logic               swap_done,
  input  logic               vsync,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIX_W-1:0]   rd_data,
  output logic               front_sel,
  output logic               busy,
  output logic               wr_err
);
  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [PIX_W-1:0]  clr_col;
  logic              vs_q, vs_prev;
  logic              rd_ok, rd_sel;
  logic              idle, vs_start, apply_swap;
  logic [PROD_W-1:0] pix_full;
  logic              pix_in_range, pix_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  rdata0, rdata1;

  assign idle      = (state == ST_IDLE);
  assign wr_ready  = idle;
  assign clr_ready = idle;
  assign busy      = !idle;

  assign pix_full     = pix_addr(wr_x, wr_y);
  assign pix_in_range = (wr_x < COORD_W'(FB_W)) && (wr_y < COORD_W'(FB_H)) &&
                        (pix_full < PROD_W'(FB_SIZE));
  assign pix_we       = idle && wr_valid && pix_in_range;

  assign ram_we    = !idle || pix_we;
  assign ram_waddr = idle ? pix_full[ADDR_W-1:0] : clr_cnt;
  assign ram_wdata = idle ? wr_color : clr_col;

  assign vs_start   = (vs_q == VS_ACT) && (vs_prev != VS_ACT);
  assign apply_swap = vs_start && swap_pending && idle;

  // Writes always go to the buffer not on screen; front_sel is the pre-toggle value here.
  fb_ram_2p u_ram0 (
    .clock (clock),
    .we    (ram_we && front_sel),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  fb_ram_2p u_ram1 (
    .clock (clock),
    .we    (ram_we && !front_sel),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  assign rd_data = rd_ok ? (rd_sel ? rdata1 : rdata0) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      clr_col <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_valid) begin
            clr_col <= clr_color;
            clr_cnt <= '0;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == ADDR_W'(FB_SIZE - 1)) begin
            state <= ST_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vs_q         <= !VS_ACT;
      vs_prev      <= !VS_ACT;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      wr_err       <= 1'b0;
      rd_ok        <= 1'b0;
      rd_sel       <= 1'b0;
    end else begin
      vs_q      <= vsync;
      vs_prev   <= vs_q;
      swap_done <= apply_swap;
      if (apply_swap) begin
        front_sel    <= !front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      if (idle && wr_valid && !pix_in_range) wr_err <= 1'b1;
      rd_ok  <= (rd_addr < ADDR_W'(FB_SIZE));
      rd_sel <= front_sel;
    end
  end
endmodule

// File: tb/tb_fb_double_buffer.sv
// tb/tb_fb_double_buffer.sv - randomized scoreboard bench for fb_double_buffer
module tb_fb_double_buffer;
  logic       clock = 1'b0;
  logic       reset;
  logic       wr_valid, wr_ready;
  logic [5:0] wr_x, wr_y;
  logic [7:0] wr_color;
  logic       clr_valid, clr_ready;
  logic [7:0] clr_color;
  logic       swap_req, swap_pending, swap_done;
  logic       vsync;
  logic [11:0] rd_addr;
  logic [7:0] rd_data;
  logic       front_sel, busy, wr_err;

  fb_double_buffer dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_color(clr_color),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
    .vsync(vsync), .rd_addr(rd_addr), .rd_data(rd_data),
    .front_sel(front_sel), .busy(busy), .wr_err(wr_err)
  );

  always #5 clock = ~clock;

  localparam int W = 58, H = 60, N = W * H;

  // Reference: two pixel arrays plus which one is on screen; "known" marks pixels ever written.
  logic [7:0] mem   [2][4096];
  bit         known [2][4096];
  int  m_front, m_pending, m_err, m_clr_left, m_clr_idx;
  logic [7:0] m_clr_col;
  bit  m_vs1, m_vs2;

  typedef struct {
    bit         rd_chk;
    logic [7:0] rd;
    bit front, pending, done, bsy, err;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset && q.size() > 0) begin
      e = q.pop_front();
      if (e.rd_chk) chk("rd_data", rd_data, e.rd);
      chk("front_sel", {7'd0, front_sel}, {7'd0, e.front});
      chk("swap_pending", {7'd0, swap_pending}, {7'd0, e.pending});
      chk("swap_done", {7'd0, swap_done}, {7'd0, e.done});
      chk("busy", {7'd0, busy}, {7'd0, e.bsy});
      chk("wr_ready", {7'd0, wr_ready}, {7'd0, !e.bsy});
      chk("wr_err", {7'd0, wr_err}, {7'd0, e.err});
    end
  end

  task automatic cyc(input bit wv, input int x, input int y, input logic [7:0] c,
                     input bit cv, input logic [7:0] cc, input bit sr, input bit vs, input int ra);
    exp_t e;
    bit   busy_pre, apply;
    int   a;
    @(negedge clock);
    wr_valid = wv; wr_x = x[5:0]; wr_y = y[5:0]; wr_color = c;
    clr_valid = cv; clr_color = cc; swap_req = sr; vsync = vs; rd_addr = ra[11:0];
    busy_pre = (m_clr_left > 0);
    e.rd_chk = (ra >= N) || known[m_front][ra];
    e.rd     = (ra >= N) ? 8'h00 : mem[m_front][ra];
    apply = (m_vs1 == 1'b0) && (m_vs2 == 1'b1) && (m_pending != 0) && !busy_pre;
    if (busy_pre) begin
      mem[1-m_front][m_clr_idx] = m_clr_col;
      known[1-m_front][m_clr_idx] = 1'b1;
      m_clr_idx++;
      m_clr_left--;
    end else begin
      if (wv) begin
        if (x < W && y < H) begin
          a = y * W + x;
          mem[1-m_front][a] = c;
          known[1-m_front][a] = 1'b1;
        end else m_err = 1;
      end
      if (cv) begin
        m_clr_left = N; m_clr_idx = 0; m_clr_col = cc;
      end
    end
    if (apply) begin
      m_front = 1 - m_front;
      m_pending = 0;
    end else if (sr) m_pending = 1;
    m_vs2 = m_vs1;
    m_vs1 = vs;
    e.front = (m_front != 0); e.pending = (m_pending != 0); e.done = apply;
    e.bsy = (m_clr_left > 0); e.err = (m_err != 0);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, $urandom_range(0, 4095));
  endtask

  task automatic do_swap();
    cyc(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, $urandom_range(0, 4095));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, $urandom_range(0, 4095));
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, $urandom_range(0, 4095));
  endtask

  task automatic sweep();
    for (int a = 0; a <= N; a++) cyc(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, a);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    wr_valid = 0; clr_valid = 0; swap_req = 0; vsync = 1; rd_addr = 0;
    wr_x = 0; wr_y = 0; wr_color = 0; clr_color = 0;
    q.delete();
    m_front = 0; m_pending = 0; m_err = 0; m_clr_left = 0; m_clr_idx = 0;
    m_vs1 = 1'b1; m_vs2 = 1'b1;
    #1;
    chk("rst rd_data", rd_data, 8'h00);
    chk("rst front_sel", {7'd0, front_sel}, 8'h00);
    chk("rst swap_pending", {7'd0, swap_pending}, 8'h00);
    chk("rst swap_done", {7'd0, swap_done}, 8'h00);
    chk("rst busy", {7'd0, busy}, 8'h00);
    chk("rst wr_err", {7'd0, wr_err}, 8'h00);
    chk("rst wr_ready", {7'd0, wr_ready}, 8'h01);
    chk("rst clr_ready", {7'd0, clr_ready}, 8'h01);
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 4096; a++) begin
        mem[b][a] = 8'h00;
        known[b][a] = 1'b0;
      end
    m_clr_col = 8'h00;
    do_reset();

    // Single pixel through a swap; (3,2) lands at linear address 119.
    cyc(1, 3, 2, 8'hA5, 0, 8'h00, 0, 1, 0);
    do_swap();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 119);

    // Full clear, swap, sweep including first out-of-range address.
    cyc(0, 0, 0, 8'h00, 1, 8'h3C, 0, 1, 0);
    idle(N + 2);
    do_swap();
    sweep();

    // Swap requested mid-clear with a vsync edge inside the clear.
    cyc(0, 0, 0, 8'h00, 1, 8'h5A, 0, 1, 0);
    idle(100);
    cyc(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 0);
    idle(1400);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, $urandom_range(0, 4095));
    idle(N);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, $urandom_range(0, 4095));
    idle(5);

    // Out-of-range writes are dropped and latch wr_err.
    cyc(1, 58, 0, 8'hEE, 0, 8'h00, 0, 1, 58);
    cyc(1, 0, 60, 8'hDD, 0, 8'h00, 0, 1, 0);
    cyc(1, 63, 63, 8'hCC, 0, 8'h00, 0, 1, 0);

    // Back-buffer write to the address being scanned out, then swap it in.
    for (int i = 0; i < 4; i++) cyc(1, 5, 5, 8'h77 + 8'(i), 0, 8'h00, 0, 1, 5 * W + 5);
    do_swap();
    sweep();

    // Reset at clear counter 1000, then a clean clear.
    cyc(0, 0, 0, 8'h00, 1, 8'h99, 0, 1, 0);
    idle(1000);
    do_reset();
    cyc(0, 0, 0, 8'h00, 1, 8'h42, 0, 1, 0);
    idle(N + 2);
    do_swap();
    sweep();

    // Randomized traffic with periodic vsync.
    for (int i = 0; i < 4000; i++) begin
      bit wv, cv, sr, vs;
      int x, y;
      wv = ($urandom_range(0, 3) != 0);
      x  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 63) : $urandom_range(0, W - 1);
      y  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 63) : $urandom_range(0, H - 1);
      cv = ($urandom_range(0, 1999) == 0);
      sr = ($urandom_range(0, 49) == 0);
      vs = !((i % 257) < 4);
      cyc(wv, x, y, 8'($urandom), cv, 8'($urandom), sr, vs, $urandom_range(0, 4095));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
